layer_activation_buffer: RTL and testbench
==========================================

// Module: layer_activation_buffer
// PURPOSE
//  Downstream stage of the layer connector. Sinks the AXI-Stream of one layer's
//  activations (NUM_IN words per frame, TLAST on last word) into a register bank.
//  Optionally applies ReLU, then fires a one-cycle start to the next layer's
//  neurons and holds the bank stable until every neuron reports done.
//  Back-pressures the stream while the next layer computes.
// PARAMETERS
//  DATA_W      32   activation width, two's-complement signed
//  NUM_IN      18   words per frame (= next-layer fan-in)
//  NUM_OUT     10   neurons in the next layer (width of neuron_done)
//  APPLY_RELU  1    1: negative words are stored as 0; 0: stored unchanged
//  CNT_W       16   width of frame_count
// PORTS
//  clk          in   1               system clock, all logic on rising edge
//  reset        in   1               asynchronous, active-high; clears all state
//  s_tdata      in   DATA_W          stream activation word
//  s_tvalid     in   1               stream word valid
//  s_tready     out  1               buffer accepts a word
//  s_tlast      in   1               last word of frame
//  act_flat     out  NUM_IN*DATA_W   bank; word i at [i*DATA_W +: DATA_W]
//  act_valid    out  1               bank is a complete, stable frame
//  layer_start  out  1               one-cycle pulse to next-layer neurons
//  neuron_done  in   NUM_OUT         per-neuron done, pulse or level
//  err_clear    in   1               clears frame_err
//  frame_err    out  1               sticky: TLAST misaligned with NUM_IN
//  frame_count  out  CNT_W           frames delivered to next layer, wraps
// BEHAVIOUR
//  Reset values: state=FILL, cnt=0, bank=0, done_seen=0, s_tready=1.
//   All other outputs reset to 0.
//  Clock/reset: one clock, clk. Reset is asynchronous, active-high, named reset.
//  States:
//   FILL  - s_tready=1, act_valid=0. Transfer = s_tvalid & s_tready.
//           On a transfer, bank[cnt] <= relu(s_tdata) and cnt++.
//   START - layer_start=1 and act_valid=1 for exactly one cycle; s_tready=0.
//           done_seen <= 0; frame_count++ (wraps at 2^CNT_W).
//   WAIT  - act_valid=1, s_tready=0; done_seen <= done_seen | neuron_done.
//           When (done_seen|neuron_done) is all ones: next state FILL, cnt=0.
//  FILL transitions:
//   - Transfer at cnt==NUM_IN-1 -> START. If s_tlast=0 there, frame_err <= 1,
//     but the frame is still delivered.
//   - Transfer with s_tlast=1 and cnt<NUM_IN-1 (short frame): frame_err <= 1,
//     cnt <= 0, stay in FILL, no start.
//  Latency: the final word is accepted in cycle N; layer_start is high in N+1.
//   The first word of the next frame is accepted no earlier than 1 cycle after
//   the last done bit arrives.
//  Bank stability: the bank is written only in FILL; it is constant while
//   act_valid=1.
//  Done timing: neuron_done during START is ignored; neurons respond at or
//   after START+1. Done bits that are already high before START do not count.
//  Errors: err_clear has priority over a new error in the same cycle.
//   frame_err reflects only TLAST misalignment.
//  relu: word[DATA_W-1]==1 -> 0 when APPLY_RELU=1. No other width change.
//  Reset mid-frame or mid-WAIT: abandon the frame. Return to FILL with cnt=0.
//   No layer_start pulse is generated.
//  s_tvalid while s_tready=0: the word is held upstream and not sampled.
// STRUCTURE
//  Shared package layer_pkg holds DATA_W, the per-layer NUM_IN/NUM_OUT
//   constants and the state enum (FILL, START, WAIT).
//  One sub-module, done_collector (NUM_OUT):
//   - sticky OR of neuron_done, with clr input driven in START;
//   - all_done output = &(sticky|neuron_done).
//  The counter, bank and FSM stay in this module.
// TESTING
//  1. Reset, then send words 0..17 back-to-back with TLAST on 17
//     -> layer_start on the cycle after word 17; act_flat word i == i;
//     frame_count=1.
//  2. APPLY_RELU=1, word 3 = 32'hFFFF_FFF0 -> bank word 3 == 0;
//     APPLY_RELU=0 -> word 3 stored as 32'hFFFF_FFF0.
//  3. In WAIT, raise done bits 0..8 at staggered cycles, then bit 9
//     -> s_tready stays 0 until 1 cycle after bit 9; bank is unchanged in WAIT.
//  4. TLAST on word 5 -> frame_err=1, no layer_start, cnt restarts;
//     then a 20-word frame with TLAST on word 19 -> start after word 17,
//     frame_err stays 1; err_clear -> 0.
//  5. Assert reset for 1 cycle after word 10 of a frame
//     -> outputs return to reset values; the next full frame delivers
//     correctly with frame_count=1.
//  6. Random s_tvalid gaps over 300 frames with done bits as 1-cycle pulses
//     -> no word lost or duplicated; frame_count=300 mod 2^CNT_W.

Source files
------------

// File: rtl/layer_pkg.sv
// -----------------------------------------------------------------------------
// layer_pkg
// Shared constants for the layer connector: activation width, the per-layer
// fan-in / neuron count, frame counter width, and the activation buffer state
// encoding.
// -----------------------------------------------------------------------------
package layer_pkg;

    localparam int DATA_W  = 32;
    localparam int NUM_IN  = 18;
    localparam int NUM_OUT = 10;
    localparam int CNT_W   = 16;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/done_collector.sv
// -----------------------------------------------------------------------------
// done_collector
// Remembers which next-layer neurons have reported done since the last start.
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   clr           clears the remembered bits (driven while the start pulse is out)
//   neuron_done   per-neuron done, pulse or level
//   all_done      every neuron has reported, counting the current cycle's bits
// -----------------------------------------------------------------------------
module done_collector #(
    parameter int NUM_OUT = layer_pkg::NUM_OUT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic [NUM_OUT-1:0] neuron_done,
    output logic               all_done
);
    import layer_pkg::*;

    logic [NUM_OUT-1:0] r_sticky;

    // clr wins so that done bits seen during the start cycle are discarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sticky <= '0;
        end else if (clr) begin
            r_sticky <= '0;
        end else begin
            r_sticky <= r_sticky | neuron_done;
        end
    end

    assign all_done = &(r_sticky | neuron_done);

endmodule

// File: rtl/layer_activation_buffer.sv
// -----------------------------------------------------------------------------
// layer_activation_buffer
// Collects one frame of activations from an AXI-Stream into a register bank,
// optionally clamping negatives to zero, pulses layer_start to the next layer
// and holds the bank stable (stream stalled) until every neuron reports done.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   s_tdata/s_tvalid/s_tready/s_tlast   activation stream (sink side)
//   act_flat            bank, word i at [i*DATA_W +: DATA_W]
//   act_valid           bank holds a complete, stable frame
//   layer_start         one-cycle start to the next layer
//   neuron_done         per-neuron done from the next layer
//   err_clear           clears frame_err
//   frame_err           sticky TLAST / frame-length misalignment flag
//   frame_count         frames delivered, wrapping
// -----------------------------------------------------------------------------
module layer_activation_buffer #(
    parameter int DATA_W     = layer_pkg::DATA_W,
    parameter int NUM_IN     = layer_pkg::NUM_IN,
    parameter int NUM_OUT    = layer_pkg::NUM_OUT,
    parameter bit APPLY_RELU = 1'b1,
    parameter int CNT_W      = layer_pkg::CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        s_tdata,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    input  logic                     s_tlast,
    output logic [NUM_IN*DATA_W-1:0] act_flat,
    output logic                     act_valid,
    output logic                     layer_start,
    input  logic [NUM_OUT-1:0]       neuron_done,
    input  logic                     err_clear,
    output logic                     frame_err,
    output logic [CNT_W-1:0]         frame_count
);
    import layer_pkg::*;

    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN - 1);

    state_t             r_state;
    state_t             w_next;
    logic [IDX_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_bank [NUM_IN];
    logic [CNT_W-1:0]   r_frame_count;
    logic               r_frame_err;
    logic               w_xfer;
    logic               w_at_last;
    logic               w_err;
    logic               w_all_done;
    logic               w_clr;

    function automatic logic [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] word);
        if (APPLY_RELU && (word < 0)) begin
            return '0;
        end
        return word;
    endfunction

    assign w_xfer    = s_tvalid & s_tready;
    assign w_at_last = (r_cnt == LAST_IDX);
    // A full-length word without TLAST, or TLAST before the frame is full.
    assign w_err     = w_xfer & (w_at_last ? ~s_tlast : s_tlast);
    assign w_clr     = (r_state == START);

    done_collector #(
        .NUM_OUT (NUM_OUT)
    ) u_done (
        .clk         (clk),
        .reset       (reset),
        .clr         (w_clr),
        .neuron_done (neuron_done),
        .all_done    (w_all_done)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FILL;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            FILL:    if (w_xfer && w_at_last) w_next = START;
            START:   w_next = WAIT;
            WAIT:    if (w_all_done) w_next = FILL;
            default: w_next = FILL;
        endcase
    end

    // Output decode
    always_comb begin
        s_tready    = 1'b0;
        act_valid   = 1'b0;
        layer_start = 1'b0;
        case (r_state)
            FILL:  s_tready = 1'b1;
            START: begin
                act_valid   = 1'b1;
                layer_start = 1'b1;
            end
            WAIT:  act_valid = 1'b1;
            default: ;
        endcase
    end

    // Word counter and bank; only written on transfers, which only occur in FILL.
    // A short frame (early TLAST) or the final word both restart the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                r_bank[i] <= '0;
            end
        end else if (w_xfer) begin
            r_bank[r_cnt] <= relu(s_tdata);
            if (w_at_last || s_tlast) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Error flag (clear has priority) and delivered-frame counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_err   <= 1'b0;
            r_frame_count <= '0;
        end else begin
            if (err_clear) begin
                r_frame_err <= 1'b0;
            end else if (w_err) begin
                r_frame_err <= 1'b1;
            end
            if (r_state == START) begin
                r_frame_count <= r_frame_count + 1'b1;
            end
        end
    end

    assign frame_err   = r_frame_err;
    assign frame_count = r_frame_count;

    for (genvar g = 0; g < NUM_IN; g++) begin : g_flat
        assign act_flat[g*DATA_W +: DATA_W] = r_bank[g];
    end

endmodule

// File: tb/tb_layer_activation_buffer.sv
module tb_layer_activation_buffer;

    localparam int DW = 32;
    localparam int NI = 18;
    localparam int NO = 10;
    localparam int CW = 16;
    localparam int FW = NI * DW;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tlast;
    logic [NO-1:0] neuron_done;
    logic          err_clear;

    logic          s_tready, act_valid, layer_start, frame_err;
    logic [FW-1:0] act_flat;
    logic [CW-1:0] frame_count;

    logic          nr_tready, nr_valid, nr_start, nr_err;
    logic [FW-1:0] nr_flat;
    logic [CW-1:0] nr_count;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [FW-1:0] exp_flat;

    always #5 clk = ~clk;

    layer_activation_buffer #(
        .DATA_W(DW), .NUM_IN(NI), .NUM_OUT(NO), .APPLY_RELU(1'b1), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tready(s_tready), .s_tlast(s_tlast), .act_flat(act_flat),
        .act_valid(act_valid), .layer_start(layer_start),
        .neuron_done(neuron_done), .err_clear(err_clear),
        .frame_err(frame_err), .frame_count(frame_count)
    );

    layer_activation_buffer #(
        .DATA_W(DW), .NUM_IN(NI), .NUM_OUT(NO), .APPLY_RELU(1'b0), .CNT_W(CW)
    ) dut_nr (
        .clk(clk), .reset(reset), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tready(nr_tready), .s_tlast(s_tlast), .act_flat(nr_flat),
        .act_valid(nr_valid), .layer_start(nr_start),
        .neuron_done(neuron_done), .err_clear(err_clear),
        .frame_err(nr_err), .frame_count(nr_count)
    );

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l);
        chk("send_ready", FW'(s_tready), FW'(1));
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        step();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    // Complete a frame: all done bits pulse together in WAIT.
    task automatic all_done_pulse();
        neuron_done = '1;
        step();
        neuron_done = '0;
        chk("done_to_fill", FW'(s_tready), FW'(1));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        logic [NO-1:0] remaining, pick;
        int            guard;

        reset = 1'b1; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        neuron_done = '0; err_clear = 1'b0;
        step(); step();
        chk("rst_ready", FW'(s_tready), FW'(1));
        chk("rst_valid", FW'(act_valid), FW'(0));
        chk("rst_start", FW'(layer_start), FW'(0));
        chk("rst_err", FW'(frame_err), FW'(0));
        chk("rst_count", FW'(frame_count), FW'(0));
        chk("rst_bank", act_flat, '0);
        reset = 1'b0;
        step();

        // ---- Test 1: words 0..17, TLAST on 17
        for (int i = 0; i < NI; i++) begin
            exp_flat[i*DW +: DW] = DW'(i);
            send(DW'(i), i == NI - 1);
        end
        chk("t1_start", FW'(layer_start), FW'(1));
        chk("t1_valid", FW'(act_valid), FW'(1));
        chk("t1_ready", FW'(s_tready), FW'(0));
        neuron_done = '1;              // ignored during START
        step();
        neuron_done = '0;
        chk("t1_start_off", FW'(layer_start), FW'(0));
        chk("t1_count", FW'(frame_count), FW'(1));
        chk("t1_bank", act_flat, exp_flat);
        step();
        chk("t1_start_done_ignored", FW'(act_valid), FW'(1));

        // ---- Test 3: staggered done bits, stream held upstream meanwhile
        s_tvalid = 1'b1;
        s_tdata  = 32'hDEAD_BEEF;
        for (int b = 0; b < NO - 1; b++) begin
            neuron_done = '0;
            neuron_done[b] = 1'b1;
            step();
            neuron_done = '0;
            step();
            chk("t3_ready_low", FW'(s_tready), FW'(0));
            chk("t3_bank_stable", act_flat, exp_flat);
        end
        s_tvalid = 1'b0;
        neuron_done = '0;
        neuron_done[NO-1] = 1'b1;
        chk("t3_ready_before_last", FW'(s_tready), FW'(0));
        step();
        neuron_done = '0;
        chk("t3_ready_after_last", FW'(s_tready), FW'(1));
        chk("t3_valid_after_last", FW'(act_valid), FW'(0));
        chk("t3_bank_kept", act_flat, exp_flat);

        // ---- Test 2: negative word with and without ReLU
        for (int i = 0; i < NI; i++) begin
            d = (i == 3) ? 32'hFFFF_FFF0 : DW'(i);
            send(d, i == NI - 1);
        end
        step();
        chk("t2_relu_w3", FW'(act_flat[3*DW +: DW]), FW'(0));
        chk("t2_relu_w4", FW'(act_flat[4*DW +: DW]), FW'(4));
        chk("t2_norelu_w3", FW'(nr_flat[3*DW +: DW]), FW'(32'hFFFF_FFF0));
        all_done_pulse();

        // ---- Test 4: short frame, then over-long frame, then err_clear
        for (int i = 0; i < 6; i++) send(DW'(i), i == 5);
        chk("t4_err_short", FW'(frame_err), FW'(1));
        chk("t4_no_start", FW'(layer_start), FW'(0));
        chk("t4_still_fill", FW'(s_tready), FW'(1));
        for (int i = 0; i < NI; i++) begin
            exp_flat[i*DW +: DW] = DW'(100 + i);
            send(DW'(100 + i), 1'b0);
            if (i == NI - 2) chk("t4_no_early_start", FW'(s_tready), FW'(1));
        end
        chk("t4_start", FW'(layer_start), FW'(1));
        chk("t4_err_kept", FW'(frame_err), FW'(1));
        step();
        chk("t4_bank", act_flat, exp_flat);
        chk("t4_count", FW'(frame_count), FW'(3));
        all_done_pulse();
        send(DW'(118), 1'b0);
        send(DW'(119), 1'b1);
        chk("t4_tail_err", FW'(frame_err), FW'(1));
        chk("t4_tail_fill", FW'(s_tready), FW'(1));
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        chk("t4_err_cleared", FW'(frame_err), FW'(0));
        err_clear = 1'b1;
        send(DW'(7), 1'b1);            // short frame in the same cycle as clear
        err_clear = 1'b0;
        chk("t4_clear_priority", FW'(frame_err), FW'(0));

        // ---- Test 5: reset mid-frame
        for (int i = 0; i < 11; i++) send(DW'(50 + i), 1'b0);
        reset = 1'b1;
        #1;
        chk("t5_ready", FW'(s_tready), FW'(1));
        chk("t5_valid", FW'(act_valid), FW'(0));
        chk("t5_start", FW'(layer_start), FW'(0));
        chk("t5_count", FW'(frame_count), FW'(0));
        chk("t5_bank", act_flat, '0);
        step();
        reset = 1'b0;
        for (int i = 0; i < NI; i++) begin
            exp_flat[i*DW +: DW] = DW'(200 + i);
            send(DW'(200 + i), i == NI - 1);
        end
        chk("t5_start_after", FW'(layer_start), FW'(1));
        step();
        chk("t5_count_after", FW'(frame_count), FW'(1));
        chk("t5_bank_after", act_flat, exp_flat);
        all_done_pulse();

        // ---- Test 6: random gaps and staggered done pulses over 300 frames
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int f = 0; f < 300; f++) begin
            for (int w = 0; w < NI; w++) begin
                if ($urandom_range(0, 2) == 0) begin
                    s_tvalid = 1'b0;
                    step();
                end
                d = $urandom;
                exp_flat[w*DW +: DW] = d[DW-1] ? '0 : d;
                send(d, w == NI - 1);
            end
            chk("t6_start", FW'(layer_start), FW'(1));
            step();
            chk("t6_bank", act_flat, exp_flat);
            remaining = '1;
            guard = 0;
            while (remaining != '0 && guard < 200) begin
                pick = NO'($urandom) & remaining;
                neuron_done = pick;
                step();
                neuron_done = '0;
                remaining = remaining & ~pick;
                guard++;
            end
            chk("t6_done_bound", FW'(remaining), FW'(0));
            chk("t6_refill", FW'(s_tready), FW'(1));
        end
        chk("t6_count", FW'(frame_count), FW'(300 % (1 << CW)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
